// File: rtl/data_sram_resp_pkg.sv
// Shared constants and helpers for the data SRAM responder.
// Holds the configuration-region decode values and the byte-lane merge used by
// both the data RAM and the memory-mapped configuration registers.
package data_sram_resp_pkg;

  // Upper address half that selects the configuration region.
  localparam logic [15:0] CONF_HI_DEF = 16'hbfaf;

  // Configuration register offsets within the region (addr[15:0]).
  localparam logic [15:0] CONF_LED    = 16'hf000;
  localparam logic [15:0] CONF_SWITCH = 16'hf020;
  localparam logic [15:0] CONF_NUM    = 16'hf050;
  localparam logic [15:0] CONF_TIMER  = 16'he000;

  // Replace byte lane i of old_w with lane i of new_w wherever be[i] is set.
  function automatic logic [31:0] byte_merge(input logic [31:0] old_w,
                                             input logic [31:0] new_w,
                                             input logic [3:0]  be);
    logic [31:0] res;
    res = old_w;
    for (int i = 0; i < 4; i++) begin
      if (be[i]) res[8*i +: 8] = new_w[8*i +: 8];
    end
    return res;
  endfunction

endpackage

// File: rtl/data_sram_resp_bank.sv
// Single-port byte-write RAM with a one-cycle registered read port.
// Read data appears on rdata_o the edge after a read request and then holds
// until the next read; writes leave rdata_o untouched. Contents are not reset.
module sram_bank_bw #(
  parameter int ADDR_W = 12
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en_i,
  input  logic [3:0]        wen_i,
  input  logic [ADDR_W-1:0] addr_i,
  input  logic [31:0]       wdata_i,
  output logic [31:0]       rdata_o
);

  logic [31:0] mem_q [2**ADDR_W];
  logic [31:0] rdata_q;

  // Storage array: per-lane writes, no reset so it maps onto block RAM.
  always_ff @(posedge clk) begin
    if (en_i) begin
      for (int i = 0; i < 4; i++) begin
        if (wen_i[i]) mem_q[addr_i][8*i +: 8] <= wdata_i[8*i +: 8];
      end
    end
  end

  // Output register: captures the pre-edge word on reads, holds otherwise.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdata_q <= 32'h0;
    end else if (en_i && (wen_i == 4'h0)) begin
      rdata_q <= mem_q[addr_i];
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/data_sram_resp.sv
// Data SRAM responder: data RAM plus LED/switch/number/timer config registers.
// Read data is returned exactly one cycle after the request; no stall ever.
// No back-pressure: every request is accepted in the cycle it is presented.
module data_sram_resp
  import data_sram_resp_pkg::*;
#(
  parameter int          RAM_ADDR_W = 12,
  parameter logic [15:0] CONF_HI    = CONF_HI_DEF
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        data_sram_en,
  input  logic [3:0]  data_sram_wen,
  input  logic [31:0] data_sram_addr,
  input  logic [31:0] data_sram_wdata,
  output logic [31:0] data_sram_rdata,
  output logic [15:0] led,
  output logic [31:0] num_data,
  input  logic [7:0]  switch
);

  logic        is_conf;
  logic [15:0] conf_off;
  logic        is_rd;
  logic        is_wr;
  logic        ram_en;
  logic [31:0] ram_rdata;

  logic [15:0] led_q,       led_d;
  logic [31:0] num_q,       num_d;
  logic [31:0] timer_q,     timer_d;
  logic [7:0]  sw_meta_q;
  logic [7:0]  sw_sync_q;
  logic [31:0] conf_rdata_q;
  logic        conf_sel_q;
  logic [31:0] conf_rd_val;
  logic [31:0] led_mrg;

  assign is_conf  = (data_sram_addr[31:16] == CONF_HI);
  assign conf_off = data_sram_addr[15:0];
  assign is_rd    = data_sram_en && (data_sram_wen == 4'h0);
  assign is_wr    = data_sram_en && (data_sram_wen != 4'h0);
  assign ram_en   = data_sram_en && !is_conf;

  // Out-of-range RAM addresses alias: only the low word-index bits are used.
  sram_bank_bw #(
    .ADDR_W (RAM_ADDR_W)
  ) u_bank (
    .clk     (clk),
    .rst_n   (resetn),
    .en_i    (ram_en),
    .wen_i   (data_sram_wen),
    .addr_i  (data_sram_addr[RAM_ADDR_W+1:2]),
    .wdata_i (data_sram_wdata),
    .rdata_o (ram_rdata)
  );

  // Config read mux: current register values, unmapped offsets read zero.
  always_comb begin
    conf_rd_val = 32'h0;
    case (conf_off)
      CONF_LED:    conf_rd_val = {16'h0, led_q};
      CONF_SWITCH: conf_rd_val = {24'h0, sw_sync_q};
      CONF_NUM:    conf_rd_val = num_q;
      CONF_TIMER:  conf_rd_val = timer_q;
      default:     conf_rd_val = 32'h0;
    endcase
  end

  assign led_mrg = byte_merge({16'h0, led_q}, data_sram_wdata, data_sram_wen);

  // Next-state for config registers; a timer write overrides the increment.
  always_comb begin
    led_d   = led_q;
    num_d   = num_q;
    timer_d = timer_q + 32'd1;
    if (is_wr && is_conf) begin
      case (conf_off)
        CONF_LED:   led_d   = led_mrg[15:0];
        CONF_NUM:   num_d   = byte_merge(num_q, data_sram_wdata, data_sram_wen);
        CONF_TIMER: timer_d = byte_merge(timer_q, data_sram_wdata, data_sram_wen);
        default:    ;
      endcase
    end
  end

  // Config registers, switch synchroniser and the read-source select flag.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      led_q        <= 16'h0;
      num_q        <= 32'h0;
      timer_q      <= 32'h0;
      sw_meta_q    <= 8'h0;
      sw_sync_q    <= 8'h0;
      conf_rdata_q <= 32'h0;
      conf_sel_q   <= 1'b0;
    end else begin
      led_q     <= led_d;
      num_q     <= num_d;
      timer_q   <= timer_d;
      sw_meta_q <= switch;
      sw_sync_q <= sw_meta_q;
      if (is_rd) begin
        conf_sel_q <= is_conf;
        if (is_conf) conf_rdata_q <= conf_rd_val;
      end
    end
  end

  // Both sources are registered and hold between reads, so the output holds too.
  assign data_sram_rdata = conf_sel_q ? conf_rdata_q : ram_rdata;
  assign led             = led_q;
  assign num_data        = num_q;

  logic unused_ok;
  assign unused_ok = ^{data_sram_addr[1:0], led_mrg[31:16]};

endmodule

// File: tb/tb_data_sram_resp.sv
// Randomised and directed bench for data_sram_resp against a behavioural model.
module tb_data_sram_resp;
  import data_sram_resp_pkg::*;

  localparam int          AW = 12;
  localparam logic [15:0] HI = 16'hbfaf;

  logic        clk;
  logic        resetn;
  logic        data_sram_en;
  logic [3:0]  data_sram_wen;
  logic [31:0] data_sram_addr;
  logic [31:0] data_sram_wdata;
  logic [31:0] data_sram_rdata;
  logic [15:0] led;
  logic [31:0] num_data;
  logic [7:0]  switch;

  data_sram_resp #(
    .RAM_ADDR_W (AW),
    .CONF_HI    (HI)
  ) dut (
    .clk             (clk),
    .resetn          (resetn),
    .data_sram_en    (data_sram_en),
    .data_sram_wen   (data_sram_wen),
    .data_sram_addr  (data_sram_addr),
    .data_sram_wdata (data_sram_wdata),
    .data_sram_rdata (data_sram_rdata),
    .led             (led),
    .num_data        (num_data),
    .switch          (switch)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural model state
  logic [31:0] m_mem [0:(1<<AW)-1];
  logic [15:0] m_led;
  logic [31:0] m_num;
  logic [31:0] m_timer;
  logic [7:0]  m_sw_hist [0:1];
  logic [31:0] m_rdata;

  int n_vec = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Bitwise lane select: bit b comes from the new word when its byte is enabled.
  function automatic logic [31:0] lane_merge(input logic [31:0] old_w,
                                             input logic [31:0] new_w,
                                             input logic [3:0]  be);
    logic [31:0] r;
    for (int b = 0; b < 32; b++) r[b] = be[b/8] ? new_w[b] : old_w[b];
    return r;
  endfunction

  function automatic logic [31:0] m_read(input logic [31:0] a);
    if (a[31:16] != HI) return m_mem[a[AW+1:2]];
    case (a[15:0])
      CONF_LED:    return {16'h0, m_led};
      CONF_SWITCH: return {24'h0, m_sw_hist[1]};
      CONF_NUM:    return m_num;
      CONF_TIMER:  return m_timer;
      default:     return 32'h0;
    endcase
  endfunction

  task automatic model_reset();
    m_led = 16'h0; m_num = 32'h0; m_timer = 32'h0; m_rdata = 32'h0;
    m_sw_hist[0] = 8'h0; m_sw_hist[1] = 8'h0;
  endtask

  // Apply one rising edge worth of behaviour using the currently driven inputs.
  task automatic model_edge();
    logic [31:0] rv, nt, tmp;
    rv = m_read(data_sram_addr);
    nt = m_timer + 32'd1;
    if (data_sram_en) begin
      if (data_sram_wen == 4'h0) begin
        m_rdata = rv;
      end else if (data_sram_addr[31:16] == HI) begin
        case (data_sram_addr[15:0])
          CONF_LED: begin
            tmp = lane_merge({16'h0, m_led}, data_sram_wdata, data_sram_wen);
            m_led = tmp[15:0];
          end
          CONF_NUM:   m_num = lane_merge(m_num, data_sram_wdata, data_sram_wen);
          CONF_TIMER: nt = lane_merge(m_timer, data_sram_wdata, data_sram_wen);
          default: ;
        endcase
      end else begin
        m_mem[data_sram_addr[AW+1:2]] = lane_merge(m_mem[data_sram_addr[AW+1:2]],
                                                  data_sram_wdata, data_sram_wen);
      end
    end
    m_timer = nt;
    m_sw_hist[1] = m_sw_hist[0];
    m_sw_hist[0] = switch;
  endtask

  task automatic cmp_cycle();
    check("rdata", data_sram_rdata, m_rdata);
    check("led", {16'h0, led}, {16'h0, m_led});
    check("num_data", num_data, m_num);
  endtask

  // Called at a falling edge: drive, clock, update model, compare at next fall.
  task automatic step(input logic e, input logic [3:0] w, input logic [31:0] a, input logic [31:0] d);
    data_sram_en = e; data_sram_wen = w; data_sram_addr = a; data_sram_wdata = d;
    @(posedge clk);
    model_edge();
    @(negedge clk);
    cmp_cycle();
  endtask

  logic [31:0] a_r;
  logic [15:0] offs [0:5];

  initial begin
    offs[0] = CONF_LED; offs[1] = CONF_SWITCH; offs[2] = CONF_NUM;
    offs[3] = CONF_TIMER; offs[4] = 16'hf100; offs[5] = 16'h0004;
    resetn = 1'b1; data_sram_en = 1'b0; data_sram_wen = 4'h0;
    data_sram_addr = 32'h0; data_sram_wdata = 32'h0; switch = 8'h0;
    #1 resetn = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);
    resetn = 1'b1;
    check("reset_rdata", data_sram_rdata, 32'h0);
    check("reset_led", {16'h0, led}, 32'h0);
    check("reset_num", num_data, 32'h0);

    // Initialise the low 64 words so random RAM reads always hit known data.
    for (int i = 0; i < 64; i++) step(1'b1, 4'hf, i << 2, $urandom);

    // RAM write then read: data appears one cycle after the read.
    step(1'b1, 4'hf, 32'h0000_0010, 32'h1234_5678);
    check("ram_hold_on_write", data_sram_rdata, m_rdata);
    step(1'b1, 4'h0, 32'h0000_0010, 32'h0);
    check("ram_rd", data_sram_rdata, 32'h1234_5678);

    // Partial byte-lane write.
    step(1'b1, 4'b0101, 32'h0000_0010, 32'hAABB_CCDD);
    step(1'b1, 4'h0, 32'h0000_0010, 32'h0);
    check("byte_lanes", data_sram_rdata, 32'h12BB_56DD);

    // Aliasing beyond RAM depth.
    step(1'b1, 4'hf, 32'h0000_0000, 32'hDEAD_BEEF);
    step(1'b1, 4'h0, 32'h0000_0004 << AW, 32'h0);
    check("alias", data_sram_rdata, 32'hDEAD_BEEF);

    // Config registers.
    step(1'b1, 4'hf, {HI, CONF_LED}, 32'hFFFF_00A5);
    check("led_out", {16'h0, led}, 32'h0000_00A5);
    step(1'b1, 4'h0, {HI, CONF_LED}, 32'h0);
    check("led_rd", data_sram_rdata, 32'h0000_00A5);
    step(1'b1, 4'hf, {HI, CONF_NUM}, 32'hCAFE_0001);
    check("num_out", num_data, 32'hCAFE_0001);
    step(1'b1, 4'h0, {HI, 16'hf100}, 32'h0);
    check("unmapped_rd", data_sram_rdata, 32'h0);

    // Timer wrap and write-over-increment.
    step(1'b1, 4'hf, {HI, CONF_TIMER}, 32'hFFFF_FFFE);
    step(1'b0, 4'h0, 32'h0, 32'h0);
    step(1'b0, 4'h0, 32'h0, 32'h0);
    step(1'b1, 4'h0, {HI, CONF_TIMER}, 32'h0);
    check("timer_wrap", data_sram_rdata, 32'h0);
    step(1'b1, 4'hf, {HI, CONF_TIMER}, 32'h5);
    step(1'b1, 4'h0, {HI, CONF_TIMER}, 32'h0);
    check("timer_wr5", data_sram_rdata, 32'h5);
    step(1'b1, 4'h0, {HI, CONF_TIMER}, 32'h0);
    check("timer_inc6", data_sram_rdata, 32'h6);

    // Switch synchroniser.
    switch = 8'h3C;
    step(1'b0, 4'h0, 32'h0, 32'h0);
    step(1'b0, 4'h0, 32'h0, 32'h0);
    step(1'b1, 4'h0, {HI, CONF_SWITCH}, 32'h0);
    check("switch_rd", data_sram_rdata, 32'h0000_003C);

    // Reset mid-run: outputs clear at once, RAM survives.
    step(1'b1, 4'hf, {HI, CONF_LED}, 32'h1);
    step(1'b1, 4'h0, 32'h0000_0010, 32'h0);
    #2 resetn = 1'b0;
    #1;
    check("mid_rst_led", {16'h0, led}, 32'h0);
    check("mid_rst_rdata", data_sram_rdata, 32'h0);
    check("mid_rst_num", num_data, 32'h0);
    model_reset();
    data_sram_en = 1'b1; data_sram_wen = 4'h0; data_sram_addr = 32'h0000_0010;
    @(posedge clk);
    @(negedge clk);
    check("rd_in_reset_ignored", data_sram_rdata, 32'h0);
    resetn = 1'b1;
    step(1'b1, 4'h0, {HI, CONF_TIMER}, 32'h0);
    check("timer_after_rst", data_sram_rdata, 32'h0);
    step(1'b1, 4'h0, 32'h0000_0010, 32'h0);
    check("ram_kept", data_sram_rdata, 32'h12BB_56DD);
    step(1'b1, 4'h0, {HI, CONF_TIMER}, 32'h0);
    check("timer_count", data_sram_rdata, 32'h2);

    // Randomised traffic.
    for (int n = 0; n < 1500; n++) begin
      if ($urandom_range(0, 7) == 0) switch = 8'($urandom);
      if ($urandom_range(0, 9) < 6) begin
        a_r = $urandom;
        if (a_r[31:16] == HI) a_r[31] = ~a_r[31];
        a_r[13:8] = 6'h0;
      end else begin
        a_r = {HI, offs[$urandom_range(0, 5)]};
      end
      step($urandom_range(0, 9) != 0,
           ($urandom_range(0, 1) == 0) ? 4'h0 : 4'($urandom),
           a_r, $urandom);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
